// File: rtl/product_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with a start/busy/done handshake.
// Optional 7-segment decode of the result is enabled by defining PRODUCT_BCD_SEG7_EN.
module product_bcd_converter #(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
`ifdef PRODUCT_BCD_SEG7_EN
    output logic [7*DIGITS-1:0]   seg,
`endif
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [IN_W-1:0]    r_shift;
    logic [SW-1:0]      r_scratch;
    logic [CW-1:0]      r_cnt;
    logic [SW-1:0]      r_bcd;

    logic [SW-1:0]      w_adj;
    logic [SW+IN_W-1:0] w_shifted;
    logic [SW-1:0]      w_scr_next;
    logic [IN_W-1:0]    w_shift_next;
    logic               w_accept;
    logic               w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CW'(1));

    // Add-3 correction is confined to each nibble; carries never cross digits.
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted    = {w_adj, r_shift} << 1;
    assign w_scr_next   = w_shifted[SW+IN_W-1:IN_W];
    assign w_shift_next = w_shifted[IN_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
        end else if (w_accept) begin
            r_shift   <= bin;
            r_scratch <= '0;
            r_cnt     <= CW'(IN_W);
        end else if (r_state == S_SHIFT) begin
            r_shift   <= w_shift_next;
            r_scratch <= w_scr_next;
            r_cnt     <= r_cnt - 1'b1;
            if (w_last) begin
                r_bcd <= w_scr_next;
            end
        end
    end

    assign bcd = r_bcd;

`ifdef PRODUCT_BCD_SEG7_EN
    // Segment order {g,f,e,d,c,b,a}, active-low; non-decimal nibbles blank.
    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        seg = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            seg[7*k +: 7] = f_seg7(r_bcd[4*k +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed self-checking bench for product_bcd_converter (IN_W=8, DIGITS=3).
module tb_product_bcd_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
`ifdef PRODUCT_BCD_SEG7_EN
    logic [20:0] seg;
`endif

    int n_checks = 0;
    int n_errors = 0;

    product_bcd_converter #(
        .IN_W   (8),
        .DIGITS (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
`ifdef PRODUCT_BCD_SEG7_EN
        .seg   (seg),
`endif
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Issues one start pulse from IDLE and waits (bounded) for done.
    task automatic run_conv(input logic [7:0] v, output logic [11:0] res, output int lat);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        res = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                res = bcd;
                break;
            end
        end
        if (lat == 0) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [11:0] res;
        int          lat;
        int          nd;
        int          busy_cnt;
        int          last_t;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        #22 rst = 1'b0;
        #1;
        // 1. reset state
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef PRODUCT_BCD_SEG7_EN
        check("rst_seg", 32'(seg), 32'(21'b1000000_1000000_1000000));
`endif

        // 2. 225: eight busy cycles then a single done
        @(negedge clk);
        bin   = 8'd225;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cnt = 0;
        nd = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                nd++;
                check("t2_done_at", 32'(i), 32'd9);
                check("t2_bcd", 32'(bcd), 32'h225);
                check("t2_excl", 32'(busy), 32'd0);
            end
        end
        check("t2_busy_cnt", 32'(busy_cnt), 32'd8);
        check("t2_done_cnt", 32'(nd), 32'd1);

        // 3a. every 8-bit value
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), res, lat);
            check("exh_bcd", 32'(res), 32'(to_bcd(v)));
            if (v == 0 || v == 255) check("exh_lat", 32'(lat), 32'd9);
        end
        // 3b. products of the 4x4 multiplier
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_conv(8'(a * b), res, lat);
                check("mul_bcd", 32'(res), 32'(to_bcd(a * b)));
            end
        end

        // 4. start during SHIFT is ignored; bin change has no effect
        @(negedge clk);
        bin   = 8'd99;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bin   = 8'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                nd++;
                check("t4_bcd", 32'(bcd), 32'h099);
            end
        end
        check("t4_done_cnt", 32'(nd), 32'd1);

        // 5. reset mid-conversion abandons it
        @(negedge clk);
        bin   = 8'd144;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_bcd", 32'(bcd), 32'h000);
        #2 rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("t5_no_done", 32'(nd), 32'd0);
        check("t5_bcd_hold", 32'(bcd), 32'h000);
        run_conv(8'd36, res, lat);
        check("t5_bcd36", 32'(res), 32'h036);
        check("t5_lat", 32'(lat), 32'd9);

        // 6. start held high: one conversion per ten cycles
        @(negedge clk);
        bin   = 8'd81;
        start = 1'b1;
        nd = 0;
        last_t = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (nd > 0) check("t6_period", 32'(i - last_t), 32'd10);
                nd++;
                last_t = i;
                check("t6_bcd", 32'(bcd), 32'h081);
            end
        end
        check("t6_done_cnt", 32'(nd), 32'd4);
        start = 1'b0;
`ifdef PRODUCT_BCD_SEG7_EN
        check("t6_seg", 32'(seg), 32'(21'b1000000_0000000_1111001));
`endif
        repeat (12) @(negedge clk);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_final_bcd", 32'(bcd), 32'h081);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
